fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Shares the single write port of the 64-deep, 8-bit FIFO between N producers. Grants are round-robin and burst-based. A new burst starts only when the FIFO has enough free space. The block sits between the producer blocks and the FIFO's write/buff_in inputs, and it observes the FIFO's full and fifo_count outputs.

Parameters:
N, 4, number of requesters (2..8)
DW, 8, data width; must equal the FIFO data width
DEPTH, 64, FIFO depth in entries
CNT_W, 8, width of fifo_count
MAX_BURST, 8, maximum beats per grant (1..DEPTH)
MIN_SPACE, 8, free entries required to start a burst (1..DEPTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  N  per-requester data valid
req_data  in  N*DW  flattened data; requester i occupies bits [i*DW +: DW]
req_ready  out  N  per-requester accept; a beat transfers when valid and ready are both high
fifo_write  out  1  drives the FIFO write input
fifo_data  out  DW  drives the FIFO buff_in input
fifo_full  in  1  FIFO full flag
fifo_count  in  CNT_W  FIFO occupancy
grant_id  out  clog2(N)  index of the current or last granted requester
busy  out  1  high while in GRANT
burst_beats  out  clog2(MAX_BURST)+1  beats transferred in the current burst

Behaviour:
- Reset (async, active-high). All of the following apply immediately:
  - state=IDLE; rr_ptr=0; grant_id=0; burst_beats=0; busy=0.
  - req_ready=0, fifo_write=0, fifo_data=0.
  - A beat in flight is dropped. Data already written to the FIFO is untouched.
- free = DEPTH - fifo_count, computed at CNT_W+1 bits with no wrap. Space_ok = (free >= MIN_SPACE).
- IDLE:
  - req_ready=0 and fifo_write=0.
  - If any req_valid is high and space_ok is true: pick the first valid requester scanning from rr_ptr upward, modulo N. Register it into grant_id, clear burst_beats, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - req_ready[grant_id] = !fifo_full. This is combinational from fifo_full.
  - All other req_ready bits are 0.
  - fifo_write = req_valid[grant_id] & !fifo_full.
  - fifo_data = req_data[grant_id]. This path is combinational and is 0 when fifo_write=0.
  - Each transfer increments burst_beats.
- Burst end. Go to IDLE and set rr_ptr = grant_id+1 (mod N) when either:
  - a transfer occurs with burst_beats+1 == MAX_BURST, or
  - req_valid[grant_id] is low (no transfer that cycle).
- Latency and bubbles:
  - Valid at edge k in IDLE gives first possible transfer in cycle k+1.
  - There is exactly one IDLE bubble cycle between consecutive bursts.
- fifo_full high during GRANT: the burst stalls (ready=0, no write). It does not end while valid stays high; there is no timeout.
- Writes are never issued while fifo_full=1. The FIFO is never overrun by this block.
- Simultaneous FIFO read in the same cycle is invisible here; it is reflected only through fifo_count and fifo_full.
- Requesters that drop valid without a transfer lose nothing. The pointer still advances past them.
- Starvation bound: any continuously valid requester is granted within N-1 bursts, given space_ok.
- grant_id holds its last value while in IDLE. busy=1 exactly in GRANT.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enum {IDLE, GRANT}.
  - Default constants DEPTH=64, DW=8, CNT_W=8.
  - Function clog2.
- One natural sub-module: rr_picker. It is combinational. Inputs: req vector and start pointer. Outputs: found flag and winner index.

Test Plan:
- Single requester: reset, then req_valid=4'b0001 with 3 beats (0xA1, 0xA2, 0xA3), count=0 → grant at cycle 1, fifo_write on 3 consecutive cycles with data A1/A2/A3, then IDLE and rr_ptr=1.
- Round-robin: all 4 requesters continuously valid, MAX_BURST=8 → grant order 0,1,2,3,0, 8 writes per burst, one bubble cycle between bursts.
- Space gating: fifo_count=57 (free=7 < MIN_SPACE=8) with valid requester → stays IDLE with no write; count drops to 56 → grant next cycle.
- Full stall: in GRANT, fifo_full=1 for 3 cycles → req_ready=0 and fifo_write=0; full deasserts → transfers resume and burst_beats continues from its prior value.
- Early release: requester 2 granted, drops valid after 2 beats → IDLE, burst_beats was 2, next scan starts at 3.
- Reset mid-burst: assert reset in GRANT after 4 beats → immediate fifo_write=0, req_ready=0, busy=0, grant_id=0; after release the first grant goes to the lowest valid index from 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, default FIFO geometry and clog2 helper
//   for the FIFO write-port arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam int DEPTH = 64;
   localparam int DW = 8;
   localparam int CNT_W = 8;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search.
//   req   : request vector
//   start : index where the search begins (wraps modulo N)
//   found : any request is set
//   idx   : first set request at or after start
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int GW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] start,
   output logic          found,
   output logic [GW-1:0] idx
);
   int j;
   // Walk the ring backwards so the candidate closest to start is written last.
   always_comb begin
      found = |req;
      idx = '0;
      j = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(start) + k;
         if (j >= N) j -= N;
         if (req[j]) idx = GW'(j);
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-based sharing of one FIFO write port.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_data  : per-requester beats (requester i at [i*DW +: DW])
//   req_ready           : per-requester accept
//   fifo_write/fifo_data: FIFO write strobe and buff_in
//   fifo_full/fifo_count: FIFO status used for stalling and space gating
//   grant_id            : current or last granted requester
//   busy                : high while a burst is granted
//   burst_beats         : beats transferred in the current burst
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int DW = fifo_arb_pkg::DW,
   parameter int DEPTH = fifo_arb_pkg::DEPTH,
   parameter int CNT_W = fifo_arb_pkg::CNT_W,
   parameter int MAX_BURST = 8,
   parameter int MIN_SPACE = 8,
   parameter int GW = clog2(N),
   parameter int BW = clog2(MAX_BURST) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req_valid,
   input  logic [N*DW-1:0]   req_data,
   output logic [N-1:0]      req_ready,
   output logic              fifo_write,
   output logic [DW-1:0]     fifo_data,
   input  logic              fifo_full,
   input  logic [CNT_W-1:0]  fifo_count,
   output logic [GW-1:0]     grant_id,
   output logic              busy,
   output logic [BW-1:0]     burst_beats
);
   localparam int FW = CNT_W + 1;
   state_t state;
   logic [GW-1:0] rr_ptr, win, next_ptr;
   logic found, space_ok, sel_valid, last_beat;
   logic [FW-1:0] free;
   rr_picker #(.N(N), .GW(GW)) u_pick (
      .req(req_valid),
      .start(rr_ptr),
      .found(found),
      .idx(win)
   );
   // An occupancy at or above DEPTH means no room; never let the subtraction wrap.
   assign free = ({1'b0, fifo_count} >= FW'(DEPTH)) ? '0 : FW'(DEPTH) - {1'b0, fifo_count};
   assign space_ok = free >= FW'(MIN_SPACE);
   assign busy = state == GRANT;
   assign sel_valid = req_valid[grant_id];
   assign fifo_write = busy && sel_valid && !fifo_full;
   assign fifo_data = fifo_write ? req_data[int'(grant_id) * DW +: DW] : '0;
   assign req_ready = (busy && !fifo_full) ? {{(N - 1){1'b0}}, 1'b1} << grant_id : '0;
   assign next_ptr = (grant_id == GW'(N - 1)) ? '0 : grant_id + 1'b1;
   assign last_beat = fifo_write && (burst_beats + BW'(1) == BW'(MAX_BURST));
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant_id <= '0;
         burst_beats <= '0;
      end else if (state == IDLE) begin
         if (found && space_ok) begin
            state <= GRANT;
            grant_id <= win;
            burst_beats <= '0;
         end
      end else begin
         if (fifo_write) burst_beats <= burst_beats + 1'b1;
         // A full FIFO with valid held stalls the burst; only a full burst or a dropped valid ends it.
         if (last_beat || !sel_valid) begin
            state <= IDLE;
            rr_ptr <= next_ptr;
         end
      end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
   logic clk = 0, reset = 1;
   logic [3:0] req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0] req_ready;
   logic fifo_write;
   logic [7:0] fifo_data;
   logic fifo_full = 0;
   logic [7:0] fifo_count = '0;
   logic [1:0] grant_id;
   logic busy;
   logic [3:0] burst_beats;
   int checks = 0, errors = 0;

   fifo_wr_arbiter dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_write(fifo_write), .fifo_data(fifo_data),
      .fifo_full(fifo_full), .fifo_count(fifo_count), .grant_id(grant_id),
      .busy(busy), .burst_beats(burst_beats)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_clean();
      reset = 1;
      req_valid = '0;
      fifo_full = 0;
      fifo_count = '0;
      cyc();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      req_valid = 4'hF;
      req_data = 32'hDDCCBBAA;
      repeat (2) cyc();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b exp 0", fifo_write); end
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h exp 0", req_ready); end
      checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", fifo_data); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
      checks++; if (burst_beats !== 4'd0) begin errors++; $display("FAIL reset_beats: got %0d exp 0", burst_beats); end
      req_valid = '0;
   endtask

   task automatic test_single();
      start_clean();
      req_data[7:0] = 8'hA1;
      req_valid = 4'b0001;
      #1;
      checks++; if (busy !== 1'b0 || fifo_write !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b write %b exp 0 0", busy, fifo_write); end
      for (int b = 0; b < 3; b++) begin
         cyc();
         req_data[7:0] = 8'hA1 + 8'(b);
         #1;
         checks++; if (fifo_write !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_write%0d: write %b busy %b exp 1 1", b, fifo_write, busy); end
         checks++; if (fifo_data !== 8'hA1 + 8'(b)) begin errors++; $display("FAIL single_data%0d: got %h exp %h", b, fifo_data, 8'hA1 + 8'(b)); end
         checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready%0d: got %b exp 0001", b, req_ready); end
         checks++; if (burst_beats !== 4'(b)) begin errors++; $display("FAIL single_beats%0d: got %0d exp %0d", b, burst_beats, b); end
      end
      cyc();
      req_valid = '0;
      #1;
      checks++; if (fifo_write !== 1'b0 || busy !== 1'b1 || burst_beats !== 4'd3) begin errors++; $display("FAIL single_drop: write %b busy %b beats %0d exp 0 1 3", fifo_write, busy, burst_beats); end
      cyc();
      #1;
      checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || burst_beats !== 4'd3) begin errors++; $display("FAIL single_end: busy %b grant %0d beats %0d exp 0 0 3", busy, grant_id, burst_beats); end
      req_data[15:8] = 8'hB7;
      req_valid = 4'b0011;
      cyc();
      #1;
      checks++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin errors++; $display("FAIL single_rrptr: grant %0d ready %b exp 1 0010", grant_id, req_ready); end
      checks++; if (fifo_data !== 8'hB7) begin errors++; $display("FAIL single_rrdata: got %h exp b7", fifo_data); end
      req_valid = '0;
      repeat (2) cyc();
   endtask

   task automatic test_round_robin();
      int bursts = 0, writes = 0, idle_run = 0;
      logic pb = 0;
      start_clean();
      req_data = 32'hC3C2C1C0;
      req_valid = 4'hF;
      for (int c = 0; c < 60 && bursts < 5; c++) begin
         cyc();
         #1;
         if (busy && !pb) begin
            checks++; if (grant_id !== 2'(bursts % 4)) begin errors++; $display("FAIL rr_order%0d: got %0d exp %0d", bursts, grant_id, bursts % 4); end
            if (bursts > 0) begin
               checks++; if (idle_run !== 1) begin errors++; $display("FAIL rr_bubble%0d: got %0d exp 1", bursts, idle_run); end
            end
            idle_run = 0;
         end
         if (fifo_write) begin
            writes++;
            checks++; if (fifo_data !== 8'hC0 + 8'(bursts % 4)) begin errors++; $display("FAIL rr_data%0d: got %h exp %h", bursts, fifo_data, 8'hC0 + 8'(bursts % 4)); end
         end
         if (!busy && pb) begin
            checks++; if (writes !== 8) begin errors++; $display("FAIL rr_writes%0d: got %0d exp 8", bursts, writes); end
            checks++; if (burst_beats !== 4'd8) begin errors++; $display("FAIL rr_beats%0d: got %0d exp 8", bursts, burst_beats); end
            writes = 0;
            bursts++;
         end
         if (!busy) idle_run++;
         pb = busy;
      end
      checks++; if (bursts !== 5) begin errors++; $display("FAIL rr_timeout: bursts %0d exp 5", bursts); end
      req_valid = '0;
      repeat (2) cyc();
   endtask

   task automatic test_space();
      start_clean();
      fifo_count = 8'd57;
      req_valid = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (busy !== 1'b0 || fifo_write !== 1'b0) begin errors++; $display("FAIL space_hold%0d: busy %b write %b exp 0 0", c, busy, fifo_write); end
         cyc();
      end
      fifo_count = 8'd56;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL space_pre: busy %b exp 0", busy); end
      cyc();
      #1;
      checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_write !== 1'b1) begin errors++; $display("FAIL space_grant: busy %b grant %0d write %b exp 1 0 1", busy, grant_id, fifo_write); end
      req_valid = '0;
      fifo_count = '0;
      repeat (2) cyc();
   endtask

   task automatic test_full_stall();
      start_clean();
      req_data[7:0] = 8'h5A;
      req_valid = 4'b0001;
      repeat (2) cyc();
      #1;
      checks++; if (fifo_write !== 1'b1 || burst_beats !== 4'd1) begin errors++; $display("FAIL stall_pre: write %b beats %0d exp 1 1", fifo_write, burst_beats); end
      cyc();
      fifo_full = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (req_ready !== 4'h0 || fifo_write !== 1'b0) begin errors++; $display("FAIL stall%0d: ready %b write %b exp 0000 0", c, req_ready, fifo_write); end
         checks++; if (busy !== 1'b1 || burst_beats !== 4'd2) begin errors++; $display("FAIL stall_hold%0d: busy %b beats %0d exp 1 2", c, busy, burst_beats); end
         if (c < 2) cyc();
      end
      cyc();
      fifo_full = 0;
      #1;
      checks++; if (fifo_write !== 1'b1 || req_ready !== 4'b0001 || burst_beats !== 4'd2) begin errors++; $display("FAIL stall_resume: write %b ready %b beats %0d exp 1 0001 2", fifo_write, req_ready, burst_beats); end
      cyc();
      #1;
      checks++; if (burst_beats !== 4'd3) begin errors++; $display("FAIL stall_count: got %0d exp 3", burst_beats); end
      req_valid = '0;
      repeat (2) cyc();
   endtask

   task automatic test_early_release();
      start_clean();
      req_data = 32'hD3E2D1D0;
      req_valid = 4'b0100;
      cyc();
      #1;
      checks++; if (grant_id !== 2'd2 || req_ready !== 4'b0100 || fifo_data !== 8'hE2) begin errors++; $display("FAIL early_grant: grant %0d ready %b data %h exp 2 0100 e2", grant_id, req_ready, fifo_data); end
      cyc();
      cyc();
      req_valid = '0;
      #1;
      checks++; if (fifo_write !== 1'b0 || burst_beats !== 4'd2) begin errors++; $display("FAIL early_drop: write %b beats %0d exp 0 2", fifo_write, burst_beats); end
      cyc();
      #1;
      checks++; if (busy !== 1'b0 || burst_beats !== 4'd2) begin errors++; $display("FAIL early_idle: busy %b beats %0d exp 0 2", busy, burst_beats); end
      req_valid = 4'hF;
      cyc();
      #1;
      checks++; if (grant_id !== 2'd3 || fifo_data !== 8'hD3) begin errors++; $display("FAIL early_next: grant %0d data %h exp 3 d3", grant_id, fifo_data); end
      req_valid = '0;
      repeat (2) cyc();
   endtask

   task automatic test_reset_mid_burst();
      start_clean();
      req_valid = 4'b0100;
      repeat (3) cyc();
      req_valid = '0;
      cyc();
      req_valid = 4'b0010;
      cyc();
      repeat (4) cyc();
      #1;
      checks++; if (busy !== 1'b1 || grant_id !== 2'd1 || burst_beats !== 4'd4) begin errors++; $display("FAIL midrst_pre: busy %b grant %0d beats %0d exp 1 1 4", busy, grant_id, burst_beats); end
      reset = 1;
      #1;
      checks++; if (fifo_write !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL midrst_out: write %b ready %b exp 0 0000", fifo_write, req_ready); end
      checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || burst_beats !== 4'd0) begin errors++; $display("FAIL midrst_state: busy %b grant %0d beats %0d exp 0 0 0", busy, grant_id, burst_beats); end
      req_valid = 4'b1010;
      cyc();
      reset = 0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_release: busy %b exp 0", busy); end
      cyc();
      #1;
      checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL midrst_regrant: busy %b grant %0d exp 1 1", busy, grant_id); end
      req_valid = '0;
      repeat (2) cyc();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_space();
      test_full_stall();
      test_early_release();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
